liteic_slave_rd_arbiter: RTL and testbench
==========================================

Name: liteic_slave_rd_arbiter

Overview:
Round-robin read-channel arbiter and sequencer for one interconnect slave port.
- Shares a single AXI-Lite AR/R slave interface between NUM_MST crossbar master slots.
- Registers the winning request and holds the grant until its R beat completes.
- Routes the R beat back to the granted slot only.
- Replaces fixed-priority selection in slave read nodes, so no master slot can be starved.

Parameters:
NUM_MST, 4, number of crossbar master slots requesting this slave
ADDR_W, 8, request address width (slave-local address bits)
DATA_W, 32, R data width, excluding the response code
TIMEOUT_CYC, 256, DATA-state cycle limit (used only with the optional feature); minimum 2
GNT_W (local), NUM_MST==1 ? 1 : $clog2(NUM_MST), grant index width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
req_val_i  in  NUM_MST  per-slot read request valid
req_addr_i  in  NUM_MST x ADDR_W  per-slot request address (unpacked array)
req_rdy_o  out  NUM_MST  per-slot request accept (one-hot or zero)
resp_rdy_i  in  NUM_MST  per-slot response ready
resp_val_o  out  NUM_MST  per-slot response valid (one-hot or zero)
resp_data_o  out  DATA_W+2  {r_data, r_resp}, shared by all slots
ar_valid_o  out  1  slave AR valid
ar_addr_o  out  ADDR_W  slave AR address
ar_ready_i  in  1  slave AR ready
r_valid_i  in  1  slave R valid
r_data_i  in  DATA_W  slave R data
r_resp_i  in  2  slave R response
r_ready_o  out  1  slave R ready
gnt_id_o  out  GNT_W  currently granted slot index
busy_o  out  1  state != IDLE

Behaviour:
- Reset (async assert, sync-released by clk_i):
  - state=IDLE, rr_ptr=0, gnt_id=0, addr_r=0.
  - All outputs 0; resp_data_o passes {r_data_i,r_resp_i} through.
  - Asserting reset mid-transaction aborts it; no response is generated afterwards.
- Round-robin pick (combinational, IDLE only):
  - Winner = first slot with req_val_i set, scanning rr_ptr, rr_ptr+1, … modulo NUM_MST.
  - NUM_MST==1: always slot 0.
- IDLE:
  - If any req_val_i: req_rdy_o[winner]=1 in the same cycle; all other bits 0.
  - Latch gnt_id=winner and addr_r=req_addr_i[winner]; next state ADDR.
  - If no request: req_rdy_o=0 and state stays IDLE.
- ADDR:
  - ar_valid_o=1 and ar_addr_o=addr_r, both stable until ar_ready_i.
  - On ar_ready_i: next state DATA.
  - ar_valid_o never drops before the handshake. The first AR is issued 1 cycle after acceptance.
- DATA:
  - resp_val_o[gnt_id]=r_valid_i; all other bits 0.
  - r_ready_o=resp_rdy_i[gnt_id]; resp_data_o={r_data_i,r_resp_i}.
  - On r_valid_i & r_ready_o: rr_ptr=gnt_id+1, wrapping to 0 when gnt_id==NUM_MST-1; next state IDLE.
- Ordering and boundaries:
  - req_rdy_o is 0 in ADDR and DATA; new requests wait.
  - Back-to-back transactions cost 1 IDLE cycle each: accept→AR→R = minimum 3 cycles/transaction.
  - A request arriving in the same cycle as the R handshake is picked in the following IDLE cycle, using the updated rr_ptr.
  - resp_val_o and r_ready_o are 0 outside DATA (and outside ERR/DRAIN when the optional feature is compiled in).
  - gnt_id_o is valid while busy_o=1.
- Requester rule: a slot keeps req_val_i and req_addr_i stable until req_rdy_o. The arbiter does not check this.

Optional Feature:
LITEIC_RD_TIMEOUT_EN
- Defined:
  - A cycle counter runs in DATA and is cleared on DATA entry.
  - If it reaches TIMEOUT_CYC-1 without an R handshake: next state ERR. An R handshake in that same cycle takes priority over the timeout.
  - ERR: resp_val_o[gnt_id]=1, resp_data_o={DATA_W'0, 2'b10} (SLVERR), r_ready_o=0. On resp_rdy_i[gnt_id]: next state DRAIN and rr_ptr advances.
  - DRAIN: r_ready_o=1, resp_val_o=0, req_rdy_o=0. The first r_valid_i beat is discarded; next state IDLE.
  - Timeouts apply to DATA only, because ar_valid_o may not be withdrawn.
- Undefined: no counter; DATA waits indefinitely; the ERR and DRAIN states do not exist.

Test Plan:
- Single request: slot 2 requests addr 0x5A, ar_ready_i=1, R returns 0xDEADBEEF/OKAY 2 cycles later → req_rdy_o=4'b0100 in cycle 0, ar_valid_o/ar_addr_o=0x5A in cycle 1, resp_val_o=4'b0100 with resp_data_o={0xDEADBEEF,2'b00}, then IDLE.
- Fairness: all 4 slots request continuously with immediate AR/R → grant order 0,1,2,3,0; each transaction 3 cycles.
- Backpressure: ar_ready_i held low 5 cycles, then resp_rdy_i[1] low 3 cycles with r_valid_i high → ar_valid_o/ar_addr_o stable throughout; r_ready_o=0 until resp_rdy_i[1]=1; no other slot accepted meanwhile.
- Wrap and skip: rr_ptr=3 (last grant slot 2), only slots 1 and 3 request → slot 3 granted, then slot 1 (rr_ptr wraps 0→1).
- Reset in DATA: rstn_i low while in DATA → all outputs 0 asynchronously; after release, a new slot 0 request is granted with rr_ptr=0.
- LITEIC_RD_TIMEOUT_EN, TIMEOUT_CYC=8: slave never returns R → after 8 DATA cycles resp_data_o low 2 bits=2'b10 for the granted slot; a later r_valid_i beat is absorbed in DRAIN, then the next request is granted.

Source files
------------

// File: rtl/liteic_slave_rd_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : liteic_slave_rd_arbiter_if
// Brief    : Master-slot request/response and slave AR/R signals of one
//            interconnect slave read node.
// Revision : 1.0
// ============================================================================
interface liteic_slave_rd_arbiter_if #(
  parameter int NUM_MST = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 32
) ();
  localparam int GNT_W = (NUM_MST == 1) ? 1 : $clog2(NUM_MST);

  logic [NUM_MST-1:0] req_val_i;
  logic [ADDR_W-1:0]  req_addr_i [NUM_MST];
  logic [NUM_MST-1:0] req_rdy_o;
  logic [NUM_MST-1:0] resp_rdy_i;
  logic [NUM_MST-1:0] resp_val_o;
  logic [DATA_W+1:0]  resp_data_o;
  logic               ar_valid_o;
  logic [ADDR_W-1:0]  ar_addr_o;
  logic               ar_ready_i;
  logic               r_valid_i;
  logic [DATA_W-1:0]  r_data_i;
  logic [1:0]         r_resp_i;
  logic               r_ready_o;
  logic [GNT_W-1:0]   gnt_id_o;
  logic               busy_o;

  modport slave (
    input  req_val_i, req_addr_i, resp_rdy_i, ar_ready_i, r_valid_i, r_data_i, r_resp_i,
    output req_rdy_o, resp_val_o, resp_data_o, ar_valid_o, ar_addr_o, r_ready_o,
           gnt_id_o, busy_o
  );

  modport master (
    output req_val_i, req_addr_i, resp_rdy_i, ar_ready_i, r_valid_i, r_data_i, r_resp_i,
    input  req_rdy_o, resp_val_o, resp_data_o, ar_valid_o, ar_addr_o, r_ready_o,
           gnt_id_o, busy_o
  );
endinterface
`default_nettype wire

// File: rtl/liteic_slave_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : liteic_slave_rd_arbiter
// Brief    : Round-robin AR/R arbiter sharing one AXI-Lite slave read port.
//            Define LITEIC_RD_TIMEOUT_EN to add the DATA-phase timeout.
// Revision : 1.0
// ============================================================================
module liteic_slave_rd_arbiter #(
  parameter int NUM_MST     = 4,
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  liteic_slave_rd_arbiter_if.slave bus
);
  localparam int GNT_W = (NUM_MST == 1) ? 1 : $clog2(NUM_MST);
  localparam logic [GNT_W-1:0] LAST_ID = GNT_W'(NUM_MST - 1);
  localparam logic [GNT_W:0]   NUM_EXT = (GNT_W + 1)'(NUM_MST);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ADDR  = 3'd1,
    ST_DATA  = 3'd2
`ifdef LITEIC_RD_TIMEOUT_EN
    ,
    ST_ERR   = 3'd3,
    ST_DRAIN = 3'd4
`endif
  } state_t;

  if (TIMEOUT_CYC < 2) begin : g_timeout_range
    $error("TIMEOUT_CYC must be at least 2");
  end

  logic [1:0]         rst_sync_q;
  logic               rst_n;
  state_t             state_q, state_d;
  logic [GNT_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [GNT_W-1:0]   gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [GNT_W-1:0]   rr_next;
  logic               win_vld;
  logic [GNT_W-1:0]   win_id;
  logic [GNT_W:0]     pick_sum;
  logic [NUM_MST-1:0] win_oh, gnt_oh;
  logic [NUM_MST-1:0] req_rdy, resp_val;
  logic               ar_valid, r_ready;
  logic [DATA_W+1:0]  resp_data;

`ifdef LITEIC_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  // Reset asserts immediately but releases only after two clock edges.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Scan downward so the slot closest to rr_ptr is the last one written.
  always_comb begin
    win_vld  = 1'b0;
    win_id   = '0;
    pick_sum = '0;
    for (int k = NUM_MST - 1; k >= 0; k--) begin
      pick_sum = {1'b0, rr_ptr_q} + (GNT_W + 1)'(k);
      if (pick_sum >= NUM_EXT) pick_sum = pick_sum - NUM_EXT;
      if (bus.req_val_i[pick_sum[GNT_W-1:0]]) begin
        win_vld = 1'b1;
        win_id  = pick_sum[GNT_W-1:0];
      end
    end
    win_oh         = '0;
    win_oh[win_id] = 1'b1;
    gnt_oh           = '0;
    gnt_oh[gnt_id_q] = 1'b1;
  end

  assign rr_next = (gnt_id_q == LAST_ID) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    gnt_id_d  = gnt_id_q;
    addr_d    = addr_q;
    req_rdy   = '0;
    resp_val  = '0;
    ar_valid  = 1'b0;
    r_ready   = 1'b0;
    resp_data = {bus.r_data_i, bus.r_resp_i};
`ifdef LITEIC_RD_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // Gated so nothing is accepted while the reset release is in flight.
        if (win_vld && rst_n) begin
          req_rdy  = win_oh;
          gnt_id_d = win_id;
          addr_d   = bus.req_addr_i[win_id];
          state_d  = ST_ADDR;
        end
      end
      ST_ADDR: begin
        ar_valid = 1'b1;
        if (bus.ar_ready_i) begin
          state_d = ST_DATA;
`ifdef LITEIC_RD_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_DATA: begin
        resp_val = gnt_oh & {NUM_MST{bus.r_valid_i}};
        r_ready  = bus.resp_rdy_i[gnt_id_q];
        if (bus.r_valid_i && r_ready) begin
          rr_ptr_d = rr_next;
          state_d  = ST_IDLE;
        end
`ifdef LITEIC_RD_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
`ifdef LITEIC_RD_TIMEOUT_EN
      ST_ERR: begin
        resp_val  = gnt_oh;
        resp_data = {{DATA_W{1'b0}}, 2'b10};
        if (bus.resp_rdy_i[gnt_id_q]) begin
          rr_ptr_d = rr_next;
          state_d  = ST_DRAIN;
        end
      end
      // The late beat of the timed-out read is swallowed here.
      ST_DRAIN: begin
        r_ready = 1'b1;
        if (bus.r_valid_i) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      gnt_id_q <= '0;
      addr_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
      addr_q   <= addr_d;
    end
  end

`ifdef LITEIC_RD_TIMEOUT_EN
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`endif

  assign bus.req_rdy_o   = req_rdy;
  assign bus.resp_val_o  = resp_val;
  assign bus.resp_data_o = resp_data;
  assign bus.ar_valid_o  = ar_valid;
  assign bus.ar_addr_o   = addr_q;
  assign bus.r_ready_o   = r_ready;
  assign bus.gnt_id_o    = gnt_id_q;
  assign bus.busy_o      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_liteic_slave_rd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_liteic_slave_rd_arbiter
// Brief    : Directed self-checking bench for liteic_slave_rd_arbiter.
// Revision : 1.0
// ============================================================================
module tb_liteic_slave_rd_arbiter;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  liteic_slave_rd_arbiter_if #(.NUM_MST(4), .ADDR_W(8), .DATA_W(32)) bus ();

  liteic_slave_rd_arbiter #(
    .NUM_MST(4), .ADDR_W(8), .DATA_W(32), .TIMEOUT_CYC(8)
  ) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .bus    (bus)
  );

  // Snapshot of every control output: req_rdy, resp_val, ar_valid, r_ready, busy, gnt_id
  logic [12:0] ctl;
  assign ctl = {bus.req_rdy_o, bus.resp_val_o, bus.ar_valid_o, bus.r_ready_o,
                bus.busy_o, bus.gnt_id_o};

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.req_val_i  = '0;
    bus.resp_rdy_i = 4'b1111;
    bus.ar_ready_i = 1'b1;
    bus.r_valid_i  = 1'b0;
    bus.r_data_i   = '0;
    bus.r_resp_i   = '0;
    for (int i = 0; i < 4; i++) bus.req_addr_i[i] = '0;
  endtask

  task automatic do_reset();
    nxt();
    rstn = 1'b0;
    clear_inputs();
    nxt(); nxt();
    rstn = 1'b1;
    nxt(); nxt(); nxt();
  endtask

  task automatic test_reset();
    clear_inputs();
    rstn = 1'b0;
    bus.req_val_i = 4'b1111;
    bus.r_data_i  = 32'h1234_5678;
    bus.r_resp_i  = 2'b01;
    #1;
    total++; if (ctl !== 13'd0) begin bad++; $display("FAIL reset_ctl got=%h exp=%h", ctl, 13'd0); end
    total++; if (bus.resp_data_o !== {32'h1234_5678, 2'b01}) begin bad++;
      $display("FAIL reset_rdata got=%h exp=%h", bus.resp_data_o, {32'h1234_5678, 2'b01}); end
    total++; if (bus.ar_addr_o !== 8'h00) begin bad++; $display("FAIL reset_araddr got=%h exp=00", bus.ar_addr_o); end
    nxt();
    bus.req_val_i = '0;
    rstn = 1'b1;
    nxt(); nxt(); nxt();
  endtask

  task automatic test_single();
    nxt();
    bus.req_val_i = 4'b0100; bus.req_addr_i[2] = 8'h5A;
    #1;
    total++; if (ctl !== {4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0}) begin bad++;
      $display("FAIL single_accept got=%h exp=%h", ctl, {4'b0100, 4'b0000, 1'b0, 1'b0, 1'b0, 2'd0}); end
    nxt();
    bus.req_val_i = '0;
    #1;
    total++; if (ctl !== {4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2}) begin bad++;
      $display("FAIL single_ar got=%h exp=%h", ctl, {4'b0000, 4'b0000, 1'b1, 1'b0, 1'b1, 2'd2}); end
    total++; if (bus.ar_addr_o !== 8'h5A) begin bad++; $display("FAIL single_araddr got=%h exp=5a", bus.ar_addr_o); end
    nxt();
    bus.r_valid_i = 1'b1; bus.r_data_i = 32'hDEAD_BEEF; bus.r_resp_i = 2'b00;
    #1;
    total++; if (ctl !== {4'b0000, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd2}) begin bad++;
      $display("FAIL single_r got=%h exp=%h", ctl, {4'b0000, 4'b0100, 1'b0, 1'b1, 1'b1, 2'd2}); end
    total++; if (bus.resp_data_o !== {32'hDEAD_BEEF, 2'b00}) begin bad++;
      $display("FAIL single_rdata got=%h exp=%h", bus.resp_data_o, {32'hDEAD_BEEF, 2'b00}); end
    nxt();
    bus.r_valid_i = 1'b0;
    #1;
    total++; if (ctl[12:2] !== 11'd0) begin bad++; $display("FAIL single_idle got=%h exp=0", ctl[12:2]); end
  endtask

  // Entry condition: rr_ptr = 3 after the slot 2 transaction.
  task automatic test_wrap();
    nxt();
    bus.req_val_i = 4'b1010; bus.req_addr_i[1] = 8'h11; bus.req_addr_i[3] = 8'h33;
    #1;
    total++; if (bus.req_rdy_o !== 4'b1000) begin bad++; $display("FAIL wrap_first got=%b exp=1000", bus.req_rdy_o); end
    nxt();
    bus.req_val_i = 4'b0010;
    #1;
    total++; if ({bus.gnt_id_o, bus.ar_addr_o} !== {2'd3, 8'h33}) begin bad++;
      $display("FAIL wrap_ar3 got=%h exp=%h", {bus.gnt_id_o, bus.ar_addr_o}, {2'd3, 8'h33}); end
    nxt();
    bus.r_valid_i = 1'b1;
    #1;
    total++; if (bus.resp_val_o !== 4'b1000) begin bad++; $display("FAIL wrap_r3 got=%b exp=1000", bus.resp_val_o); end
    nxt();
    bus.r_valid_i = 1'b0;
    #1;
    total++; if (bus.req_rdy_o !== 4'b0010) begin bad++; $display("FAIL wrap_second got=%b exp=0010", bus.req_rdy_o); end
    nxt();
    bus.req_val_i = '0;
    #1;
    total++; if ({bus.gnt_id_o, bus.ar_addr_o} !== {2'd1, 8'h11}) begin bad++;
      $display("FAIL wrap_ar1 got=%h exp=%h", {bus.gnt_id_o, bus.ar_addr_o}, {2'd1, 8'h11}); end
    nxt();
    bus.r_valid_i = 1'b1;
    #1;
    total++; if (bus.resp_val_o !== 4'b0010) begin bad++; $display("FAIL wrap_r1 got=%b exp=0010", bus.resp_val_o); end
    nxt();
    bus.r_valid_i = 1'b0;
  endtask

  // Entry condition: rr_ptr = 2, so a stale pointer would pick slot 3 over slot 0.
  task automatic test_reset_in_data();
    nxt();
    bus.req_val_i = 4'b0100; bus.req_addr_i[2] = 8'h44;
    nxt();
    bus.req_val_i = '0;
    nxt();
    #1;
    total++; if (ctl !== {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2}) begin bad++;
      $display("FAIL rstdata_pre got=%h exp=%h", ctl, {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1, 2'd2}); end
    #2;
    rstn = 1'b0;
    bus.req_val_i = 4'b1001; bus.req_addr_i[0] = 8'h0C; bus.req_addr_i[3] = 8'h3C;
    bus.r_valid_i = 1'b1;
    #1;
    total++; if (ctl !== 13'd0) begin bad++; $display("FAIL rstdata_async got=%h exp=0", ctl); end
    nxt(); nxt();
    rstn = 1'b1;
    nxt();
    #1;
    total++; if (ctl !== 13'd0) begin bad++; $display("FAIL rstdata_release got=%h exp=0", ctl); end
    nxt();
    #1;
    total++; if (bus.req_rdy_o !== 4'b0001) begin bad++; $display("FAIL rstdata_grant got=%b exp=0001", bus.req_rdy_o); end
    nxt();
    bus.req_val_i = '0; bus.r_valid_i = 1'b0;
    #1;
    total++; if ({bus.gnt_id_o, bus.ar_addr_o} !== {2'd0, 8'h0C}) begin bad++;
      $display("FAIL rstdata_ar got=%h exp=%h", {bus.gnt_id_o, bus.ar_addr_o}, {2'd0, 8'h0C}); end
    nxt();
    bus.r_valid_i = 1'b1;
    #1;
    total++; if (bus.resp_val_o !== 4'b0001) begin bad++; $display("FAIL rstdata_r got=%b exp=0001", bus.resp_val_o); end
    nxt();
    bus.r_valid_i = 1'b0;
  endtask

  task automatic test_fairness();
    logic [3:0] oh;
    logic [1:0] exp_id;
    do_reset();
    for (int i = 0; i < 4; i++) bus.req_addr_i[i] = 8'h10 + 8'(i);
    bus.req_val_i = 4'b1111;
    bus.r_valid_i = 1'b1;
    bus.r_data_i  = 32'hCAFE_0000;
    for (int t = 0; t < 5; t++) begin
      exp_id = 2'(t % 4);
      oh = 4'b0001 << exp_id;
      #1;
      total++; if (bus.req_rdy_o !== oh) begin bad++;
        $display("FAIL fair_accept t=%0d got=%b exp=%b", t, bus.req_rdy_o, oh); end
      nxt();
      #1;
      total++; if ({bus.ar_valid_o, bus.gnt_id_o, bus.ar_addr_o} !== {1'b1, exp_id, 8'h10 + 8'(exp_id)}) begin bad++;
        $display("FAIL fair_ar t=%0d got=%h exp=%h", t, {bus.ar_valid_o, bus.gnt_id_o, bus.ar_addr_o},
                 {1'b1, exp_id, 8'h10 + 8'(exp_id)}); end
      nxt();
      #1;
      total++; if (bus.resp_val_o !== oh) begin bad++;
        $display("FAIL fair_r t=%0d got=%b exp=%b", t, bus.resp_val_o, oh); end
      nxt();
    end
    bus.req_val_i = '0;
    bus.r_valid_i = 1'b0;
  endtask

  // Entry condition: rr_ptr = 1.
  task automatic test_backpressure();
    int stable_bad = 0;
    bus.req_val_i = 4'b0010; bus.req_addr_i[1] = 8'h33; bus.req_addr_i[3] = 8'h7E;
    bus.ar_ready_i = 1'b0;
    #1;
    total++; if (bus.req_rdy_o !== 4'b0010) begin bad++; $display("FAIL bp_accept got=%b exp=0010", bus.req_rdy_o); end
    nxt();
    bus.req_val_i = 4'b1000;
    for (int c = 0; c < 6; c++) begin
      if (c == 5) bus.ar_ready_i = 1'b1;
      #1;
      if ({bus.req_rdy_o, bus.ar_valid_o, bus.ar_addr_o} !== {4'b0000, 1'b1, 8'h33}) stable_bad++;
      nxt();
    end
    total++; if (stable_bad != 0) begin bad++; $display("FAIL bp_ar_stable got=%0d unstable cycles exp=0", stable_bad); end
    bus.r_valid_i = 1'b1; bus.r_data_i = 32'h0BAD_F00D; bus.resp_rdy_i = 4'b1101;
    stable_bad = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      if (ctl !== {4'b0000, 4'b0010, 1'b0, 1'b0, 1'b1, 2'd1}) stable_bad++;
      nxt();
    end
    total++; if (stable_bad != 0) begin bad++; $display("FAIL bp_r_hold got=%0d bad cycles exp=0", stable_bad); end
    bus.resp_rdy_i = 4'b1111;
    #1;
    total++; if ({bus.r_ready_o, bus.resp_val_o} !== {1'b1, 4'b0010}) begin bad++;
      $display("FAIL bp_r_done got=%b exp=%b", {bus.r_ready_o, bus.resp_val_o}, {1'b1, 4'b0010}); end
    nxt();
    bus.r_valid_i = 1'b0;
    #1;
    total++; if (bus.req_rdy_o !== 4'b1000) begin bad++; $display("FAIL bp_next got=%b exp=1000", bus.req_rdy_o); end
    nxt();
    bus.req_val_i = '0;
    nxt();
    bus.r_valid_i = 1'b1;
    nxt();
    bus.r_valid_i = 1'b0;
  endtask

`ifdef LITEIC_RD_TIMEOUT_EN
  // Entry condition: rr_ptr = 0.
  task automatic test_timeout();
    int early = 0;
    nxt();
    bus.req_val_i = 4'b0001; bus.req_addr_i[0] = 8'h77;
    nxt();
    bus.req_val_i = '0; bus.resp_rdy_i = 4'b0000;
    nxt();
    for (int c = 0; c < 8; c++) begin
      #1;
      if ({bus.resp_val_o, bus.busy_o} !== {4'b0000, 1'b1}) early++;
      nxt();
    end
    total++; if (early != 0) begin bad++; $display("FAIL tmo_data got=%0d bad cycles exp=0", early); end
    #1;
    total++; if ({bus.resp_val_o, bus.r_ready_o, bus.resp_data_o} !== {4'b0001, 1'b0, 32'h0, 2'b10}) begin bad++;
      $display("FAIL tmo_err got=%h exp=%h", {bus.resp_val_o, bus.r_ready_o, bus.resp_data_o},
               {4'b0001, 1'b0, 32'h0, 2'b10}); end
    nxt();
    bus.resp_rdy_i = 4'b1111;
    #1;
    total++; if (bus.resp_val_o !== 4'b0001) begin bad++; $display("FAIL tmo_err_hold got=%b exp=0001", bus.resp_val_o); end
    nxt();
    bus.req_val_i = 4'b0010; bus.req_addr_i[1] = 8'h21;
    #1;
    total++; if (ctl[12:2] !== {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1}) begin bad++;
      $display("FAIL tmo_drain got=%h exp=%h", ctl[12:2], {4'b0000, 4'b0000, 1'b0, 1'b1, 1'b1}); end
    nxt();
    bus.r_valid_i = 1'b1;
    #1;
    total++; if ({bus.resp_val_o, bus.r_ready_o} !== {4'b0000, 1'b1}) begin bad++;
      $display("FAIL tmo_absorb got=%b exp=%b", {bus.resp_val_o, bus.r_ready_o}, {4'b0000, 1'b1}); end
    nxt();
    bus.r_valid_i = 1'b0;
    #1;
    total++; if (bus.req_rdy_o !== 4'b0010) begin bad++; $display("FAIL tmo_next got=%b exp=0010", bus.req_rdy_o); end
    nxt();
    bus.req_val_i = '0;
    nxt();
    bus.r_valid_i = 1'b1;
    #1;
    total++; if (bus.resp_val_o !== 4'b0010) begin bad++; $display("FAIL tmo_next_r got=%b exp=0010", bus.resp_val_o); end
    nxt();
    bus.r_valid_i = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_reset_in_data();
    test_fairness();
    test_backpressure();
`ifdef LITEIC_RD_TIMEOUT_EN
    test_timeout();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
